// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - instruction-memory and IF/ID handshake bundle for if_fetch_queue
//
// Purpose: groups the imem read channel and the IF/ID instruction channel.
// Signals:
//   imem_req    fetch -> imem   read request (one outstanding at most)
//   imem_addr   fetch -> imem   read address
//   imem_ack    imem  -> fetch  read data valid, one pulse per request
//   imem_data   imem  -> fetch  read data
//   inst_valid  fetch -> ID     head entry valid
//   inst        fetch -> ID     head instruction
//   inst_pc     fetch -> ID     PC of head instruction
//   inst_ready  ID    -> fetch  ID consumes the head this cycle
// Modports: master = fetch queue side, slave = memory/decode environment side.

interface if_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_data, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_data, inst_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - fetch stage: single-outstanding imem reads into a small {pc,instr} queue
//
// Purpose: issues one instruction-memory read at a time from pc_i, advances the PC register
// (pc_we_o) only when a fetch is issued, and buffers returned {pc,instr} pairs for IF/ID.
// A redirect (flush_i) empties the queue and discards any in-flight response.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous, active-low reset
//   pc_i     in   current PC from the PC register
//   pc_we_o  out  PC write enable, high exactly in the issue cycle
//   flush_i  in   redirect: drop queue and in-flight fetch
//   bus      if   if_fetch_queue_if.master (imem read channel + IF/ID channel)
// Parameter: DEPTH queue entries (power of two, >= 2).
// Build option: IF_FETCH_BYPASS_EN defined forwards an ack straight to IF/ID when the queue
// is empty; undefined, inst_* come only from registered storage.

module if_fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            pc_i,
  output logic                   pc_we_o,
  input  logic                   flush_i,
  if_fetch_queue_if.master       bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [31:0]     req_pc_q;
  logic [31:0]     mem_pc_q    [DEPTH];
  logic [31:0]     mem_instr_q [DEPTH];

  logic            issue;
  logic            push;
  logic            push_store;
  logic            pop;
  logic            byp;

  // Next-state and request generation. rst_i gates the IDLE issue so that all
  // outputs are quiet while reset is held.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_i && (count_q < DEPTH_C) && !flush_i) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_ack) begin
          push    = !flush_i;
          state_d = IDLE;
        end else if (flush_i) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.imem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef IF_FETCH_BYPASS_EN
  // Empty queue and a live response: hand it to ID in the ack cycle.
  assign byp = (state_q == WAIT) && bus.imem_ack && !flush_i && (count_q == '0);
`else
  assign byp = 1'b0;
`endif

  // A bypassed entry taken by ID this cycle never enters storage.
  assign push_store = push && !(byp && bus.inst_ready);
  assign pop        = (count_q != '0) && bus.inst_ready && !flush_i;

  assign pc_we_o        = issue;
  assign bus.imem_req   = issue;
  assign bus.imem_addr  = issue ? pc_i : 32'h0;
  assign bus.inst_valid = (count_q != '0) || byp;
  assign bus.inst       = byp ? bus.imem_data : mem_instr_q[rd_ptr_q];
  assign bus.inst_pc    = byp ? req_pc_q      : mem_pc_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      req_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (issue) begin
        req_pc_q <= pc_i;
      end
      if (flush_i) begin
        // Redirect wins over push and pop; push is already suppressed above.
        count_q  <= '0;
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (push_store) begin
          mem_pc_q[wr_ptr_q]    <= req_pc_q;
          mem_instr_q[wr_ptr_q] <= bus.imem_data;
          wr_ptr_q              <= wr_ptr_q + PW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        case ({push_store, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - self-checking bench for if_fetch_queue with a queue-based reference model

module tb_if_fetch_queue;

  localparam int DEPTH = 2;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        pc_we_o;
  logic        flush_i;

  if_fetch_queue_if bus();

  if_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pc_i    (pc_i),
    .pc_we_o (pc_we_o),
    .flush_i (flush_i),
    .bus     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: queue of {pc,instr}, one outstanding fetch that may be marked stale.
  logic [63:0] q[$];
  bit          pending;
  bit          stale;
  logic [31:0] ppc;
  // Memory model: busy flag and cycles left before the ack pulse.
  bit          mem_busy;
  int          mem_delay;
  int          lat;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] pc, input logic fl, input logic rdy, input logic [31:0] dat);
    logic ack_now, exp_req, byp, pop_now;
    @(negedge clk_i);
    pc_i           = pc;
    flush_i        = fl;
    bus.inst_ready = rdy;
    bus.imem_data  = dat;
    ack_now        = mem_busy && (mem_delay == 0);
    bus.imem_ack   = ack_now;
    #1;
    exp_req = !pending && (q.size() < DEPTH) && !fl;
    byp     = 1'b0;
`ifdef IF_FETCH_BYPASS_EN
    byp = ack_now && pending && !stale && !fl && (q.size() == 0);
`endif
    check_val("imem_req", bus.imem_req, exp_req);
    check_val("pc_we", pc_we_o, exp_req);
    check_val("imem_addr", bus.imem_addr, exp_req ? pc : 32'h0);
    check_val("inst_valid", bus.inst_valid, (q.size() != 0) || byp);
    if (byp) begin
      check_val("inst_byp", bus.inst, dat);
      check_val("inst_pc_byp", bus.inst_pc, ppc);
    end else if (q.size() != 0) begin
      check_val("inst", bus.inst, q[0][31:0]);
      check_val("inst_pc", bus.inst_pc, q[0][63:32]);
    end
    // Advance the model to the state after the coming rising edge.
    pop_now = (q.size() != 0) && rdy && !fl;
    if (pop_now) void'(q.pop_front());
    if (ack_now && pending) begin
      if (!stale && !fl && !(byp && rdy)) q.push_back({ppc, dat});
      pending = 0;
      stale   = 0;
    end else if (fl && pending) begin
      stale = 1;
    end
    if (fl) q.delete();
    if (ack_now) mem_busy = 0;
    else if (mem_busy) mem_delay--;
    if (exp_req) begin
      pending   = 1;
      stale     = 0;
      ppc       = pc;
      mem_busy  = 1;
      mem_delay = (lat == 0) ? int'($urandom_range(0, 2)) : lat - 1;
    end
  endtask

  // Reset asserted between edges; memory model keeps any outstanding ack so it arrives late.
  task automatic do_reset(input logic [31:0] pc);
    @(negedge clk_i);
    pc_i         = pc;
    flush_i      = 1'b0;
    bus.imem_ack = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    check_val("rst_req", bus.imem_req, 32'h0);
    check_val("rst_pc_we", pc_we_o, 32'h0);
    check_val("rst_addr", bus.imem_addr, 32'h0);
    check_val("rst_valid", bus.inst_valid, 32'h0);
    check_val("rst_inst", bus.inst, 32'h0);
    check_val("rst_inst_pc", bus.inst_pc, 32'h0);
    pending = 0;
    stale   = 0;
    q.delete();
    repeat (2) @(negedge clk_i);
    flush_i = 1'b1;
    rst_i   = 1'b1;
  endtask

  // Flush until the memory is idle so each directed case starts empty in IDLE.
  task automatic drain();
    for (int i = 0; i < 8 && mem_busy; i++) step(32'h0, 1'b1, 1'b1, 32'h0);
    step(32'h0, 1'b1, 1'b1, 32'h0);
  endtask

  initial begin
    rst_i          = 1'b0;
    pc_i           = 32'h0;
    flush_i        = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_data  = 32'h0;
    bus.inst_ready = 1'b0;
    pending  = 0;
    stale    = 0;
    ppc      = 32'h0;
    mem_busy = 0;
    mem_delay = 0;
    lat      = 1;

    do_reset(32'h0000_0040);

    // Reset with a fetch in WAIT; the late ack must be ignored, next req at pc 0.
    lat = 3;
    step(32'h0000_1000, 1'b0, 1'b1, 32'h0);
    do_reset(32'hABCD_0000);
    for (int i = 0; i < 8 && mem_busy; i++) step(32'h0, 1'b1, 1'b1, 32'h1234_5678);
    lat = 1;
    step(32'h0000_0000, 1'b0, 1'b1, 32'h0);
    step(32'h0000_0004, 1'b0, 1'b1, 32'h0000_0013);
    drain();

    // Basic fetch with 1-cycle memory.
    step(32'h0000_0100, 1'b0, 1'b1, 32'h0);
    step(32'h0000_0104, 1'b0, 1'b1, 32'h2002_0005);
    step(32'h0000_0104, 1'b0, 1'b1, 32'h0);
    step(32'h0000_0108, 1'b0, 1'b1, 32'h0000_0033);
    drain();

    // Fill the queue with ID stalled, then release for one cycle.
    step(32'h0000_0300, 1'b0, 1'b0, 32'h0);
    step(32'h0000_0304, 1'b0, 1'b0, 32'h0000_00A1);
    step(32'h0000_0304, 1'b0, 1'b0, 32'h0);
    step(32'h0000_0308, 1'b0, 1'b0, 32'h0000_00A2);
    step(32'h0000_0308, 1'b0, 1'b0, 32'h0);
    step(32'h0000_0308, 1'b0, 1'b0, 32'h0);
    step(32'h0000_0308, 1'b0, 1'b1, 32'h0);
    step(32'h0000_0308, 1'b0, 1'b0, 32'h0);
    step(32'h0000_030C, 1'b0, 1'b1, 32'h0000_00A3);
    step(32'h0000_030C, 1'b0, 1'b1, 32'h0);
    drain();

    // Flush while a fetch is in flight; ack arrives in DROP.
    lat = 4;
    step(32'h0000_0200, 1'b0, 1'b1, 32'h0);
    step(32'h0000_0200, 1'b1, 1'b1, 32'h0);
    step(32'h0000_0400, 1'b0, 1'b1, 32'h0);
    step(32'h0000_0400, 1'b0, 1'b1, 32'h0);
    step(32'h0000_0400, 1'b0, 1'b1, 32'hDEAD_BEEF);
    lat = 1;
    step(32'h0000_0400, 1'b0, 1'b1, 32'h0);
    step(32'h0000_0404, 1'b0, 1'b1, 32'h0000_0400);
    step(32'h0000_0404, 1'b0, 1'b1, 32'h0);
    drain();

    // Flush and ack together with one entry queued.
    step(32'h0000_0500, 1'b0, 1'b0, 32'h0);
    step(32'h0000_0504, 1'b0, 1'b0, 32'h0000_0B01);
    step(32'h0000_0504, 1'b0, 1'b0, 32'h0);
    step(32'h0000_0508, 1'b1, 1'b0, 32'h0000_0B02);
    step(32'h0000_0600, 1'b0, 1'b1, 32'h0);
    step(32'h0000_0604, 1'b0, 1'b1, 32'h0000_0C01);
    drain();

    // Empty queue, ack with ID ready (bypass case when enabled).
    step(32'h0000_0700, 1'b0, 1'b1, 32'h0);
    step(32'h0000_0704, 1'b0, 1'b1, 32'h0000_0020);
    step(32'h0000_0704, 1'b0, 1'b1, 32'h0);
    step(32'h0000_0708, 1'b0, 1'b0, 32'h0000_0021);
    step(32'h0000_0708, 1'b0, 1'b1, 32'h0);
    drain();

    // Randomized traffic: random latency, stalls and redirects.
    lat = 0;
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc      = $urandom;
      rpc[1:0] = 2'b00;
      step(rpc, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
